// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan controller for a shared
// hex-to-seven-segment decoder on a common-anode display.
// A frame buffer snapshots digits/dp/blank once per frame so the scan
// never shows a mix of old and new values within one frame.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zeros).
module seg_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  output logic [3:0]                    hex_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_done
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        prescaler;
  logic [SEL_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] buf_digits;
  logic [NUM_DIGITS-1:0]   buf_dp;
  logic [NUM_DIGITS-1:0]   buf_blank;
  logic                    load_pending;

  logic                    tick;
  logic                    wrap;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [3:0]              next_hex;
  logic                    next_dp;
  logic [NUM_DIGITS-1:0]   next_an;

  assign tick    = enable && (prescaler == PRE_MAX);
  assign wrap    = tick && (idx == LAST_IDX);
  assign capture = enable && (load_pending || wrap);

  // Effective per-digit blanking: the buffered request, optionally
  // widened by leading-zero suppression (digit 0 always stays visible).
  always_comb begin
    eff_blank = buf_blank;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        zero_run = zero_run && (buf_digits[4*i +: 4] == 4'h0);
        if (zero_run) eff_blank[i] = 1'b1;
      end
    end
`endif
  end

  // Select the nibble, decimal point and anode pattern for the current index.
  always_comb begin
    next_hex = 4'h0;
    next_dp  = 1'b1;
    next_an  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == i[SEL_W-1:0]) begin
        next_hex = buf_digits[4*i +: 4];
        next_dp  = ~(buf_dp[i] && !eff_blank[i]);
        if (!eff_blank[i]) next_an[i] = 1'b0;
      end
    end
  end

  // Prescaler, digit index, frame buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler    <= '0;
      idx          <= '0;
      buf_digits   <= '0;
      buf_dp       <= '0;
      buf_blank    <= '0;
      load_pending <= 1'b1;
      hex_out      <= 4'h0;
      dp_out       <= 1'b1;
      an_out       <= '1;
      digit_sel    <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        idx       <= wrap ? '0 : idx + SEL_W'(1);
      end else if (enable) begin
        prescaler <= prescaler + PRE_W'(1);
      end
      frame_done <= wrap;
      if (capture) begin
        buf_digits   <= digits_in;
        buf_dp       <= dp_in;
        buf_blank    <= blank_in;
        load_pending <= 1'b0;
      end
      hex_out   <= next_hex;
      dp_out    <= next_dp;
      an_out    <= next_an;
      digit_sel <= idx;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed, table-driven bench for seg_scan_controller.
// Main DUT: NUM_DIGITS=4, REFRESH_DIV=4. Second DUT: NUM_DIGITS=2, REFRESH_DIV=1.
module tb_seg_scan_controller;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  blank;
    int          cycles;
    logic [3:0]  e_an;
    logic [3:0]  e_hex;
    logic        e_dp;
    logic [1:0]  e_sel;
    logic        e_fd;
    string       name;
  } vec_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] ZERO_D3_AN = 4'b1111;
`else
  localparam logic [3:0] ZERO_D3_AN = 4'b0111;
`endif

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;
  logic [3:0]  hex_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_sel;
  logic        frame_done;

  logic        reset2, enable2;
  logic [7:0]  digits2;
  logic [1:0]  dp2, blank2;
  logic [3:0]  hex2;
  logic        dp_out2;
  logic [1:0]  an2;
  logic        sel2;
  logic        fd2;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .hex_out(hex_out), .dp_out(dp_out),
    .an_out(an_out), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  seg_scan_controller #(.NUM_DIGITS(2), .REFRESH_DIV(1)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .digits_in(digits2),
    .dp_in(dp2), .blank_in(blank2), .hex_out(hex2), .dp_out(dp_out2),
    .an_out(an2), .digit_sel(sel2), .frame_done(fd2)
  );

  function automatic vec_t mk(logic rst, logic en, logic [15:0] dig, logic [3:0] dp,
                              logic [3:0] blank, int cycles, logic [3:0] e_an,
                              logic [3:0] e_hex, logic e_dp, logic [1:0] e_sel,
                              logic e_fd, string name);
    vec_t v;
    v.rst = rst; v.en = en; v.dig = dig; v.dp = dp; v.blank = blank;
    v.cycles = cycles; v.e_an = e_an; v.e_hex = e_hex; v.e_dp = e_dp;
    v.e_sel = e_sel; v.e_fd = e_fd; v.name = name;
    return v;
  endfunction

  task automatic check_val(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    reset     = v.rst;
    enable    = v.en;
    digits_in = v.dig;
    dp_in     = v.dp;
    blank_in  = v.blank;
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_output(vec_t v);
    check_val({v.name, ".an"},  32'(an_out),     32'(v.e_an));
    check_val({v.name, ".hex"}, 32'(hex_out),    32'(v.e_hex));
    check_val({v.name, ".dp"},  32'(dp_out),     32'(v.e_dp));
    check_val({v.name, ".sel"}, 32'(digit_sel),  32'(v.e_sel));
    check_val({v.name, ".fd"},  32'(frame_done), 32'(v.e_fd));
  endtask

  task automatic check2(string name, logic [1:0] e_an, logic [3:0] e_hex,
                        logic e_dp, logic e_sel, logic e_fd);
    check_val({name, ".an"},  32'(an2),     32'(e_an));
    check_val({name, ".hex"}, 32'(hex2),    32'(e_hex));
    check_val({name, ".dp"},  32'(dp_out2), 32'(e_dp));
    check_val({name, ".sel"}, 32'(sel2),    32'(e_sel));
    check_val({name, ".fd"},  32'(fd2),     32'(e_fd));
  endtask

  initial begin
    reset2 = 1'b1; enable2 = 1'b0; digits2 = 8'h00; dp2 = 2'b00; blank2 = 2'b00;

    // Basic scan of 1A2F, frame_done every 16 cycles
    vecs.push_back(mk(1, 0, 16'h1A2F, 4'b0000, 4'b0000,  2, 4'b1111, 4'h0, 1, 0, 0, "reset"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  1, 4'b1110, 4'h0, 1, 0, 0, "first_edge"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  1, 4'b1110, 4'hF, 1, 0, 0, "d0_f1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  3, 4'b1101, 4'h2, 1, 1, 0, "d1_f1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  4, 4'b1011, 4'hA, 1, 2, 0, "d2_f1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  4, 4'b0111, 4'h1, 1, 3, 0, "d3_f1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  3, 4'b0111, 4'h1, 1, 3, 1, "fd_f1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  1, 4'b1110, 4'hF, 1, 0, 0, "d0_f2"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0000, 4'b0000,  4, 4'b1101, 4'h2, 1, 1, 0, "d1_f2"));
    // Input change mid-frame stays hidden until the wrap
    vecs.push_back(mk(0, 1, 16'h0000, 4'b0000, 4'b0000,  4, 4'b1011, 4'hA, 1, 2, 0, "tear_d2"));
    vecs.push_back(mk(0, 1, 16'h0000, 4'b0000, 4'b0000,  4, 4'b0111, 4'h1, 1, 3, 0, "tear_d3"));
    vecs.push_back(mk(0, 1, 16'h0000, 4'b0000, 4'b0000,  3, 4'b0111, 4'h1, 1, 3, 1, "fd_f2"));
    vecs.push_back(mk(0, 1, 16'h0000, 4'b0000, 4'b0000,  1, 4'b1110, 4'h0, 1, 0, 0, "zero_d0"));
    // Blank digit 2, dp on digit 0
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100, 15, ZERO_D3_AN, 4'h0, 1, 3, 1, "zero_d3_fd"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  1, 4'b1110, 4'hF, 0, 0, 0, "dp_d0"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  4, 4'b1101, 4'h2, 1, 1, 0, "dp_d1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  4, 4'b1111, 4'hA, 1, 2, 0, "blank_d2"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  4, 4'b0111, 4'h1, 1, 3, 0, "dp_d3"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  4, 4'b1110, 4'hF, 0, 0, 0, "d0_f4"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  5, 4'b1101, 4'h2, 1, 1, 0, "d1_pre_hold"));
    // Enable held low for 10 cycles in the idx=1 slot
    vecs.push_back(mk(0, 0, 16'h1A2F, 4'b0001, 4'b0100,  5, 4'b1101, 4'h2, 1, 1, 0, "hold_a"));
    vecs.push_back(mk(0, 0, 16'h1A2F, 4'b0001, 4'b0100,  5, 4'b1101, 4'h2, 1, 1, 0, "hold_b"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  2, 4'b1101, 4'h2, 1, 1, 0, "resume_d1"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  1, 4'b1111, 4'hA, 1, 2, 0, "resume_d2"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  4, 4'b0111, 4'h1, 1, 3, 0, "resume_d3"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  3, 4'b0111, 4'h1, 1, 3, 1, "fd_resume"));
    vecs.push_back(mk(0, 1, 16'h1A2F, 4'b0001, 4'b0100,  5, 4'b1101, 4'h2, 1, 1, 0, "pre_reset"));
    // Reset mid-frame, then a fresh capture with a full digit-0 slot
    vecs.push_back(mk(1, 1, 16'h1A2F, 4'b0001, 4'b0100,  1, 4'b1111, 4'h0, 1, 0, 0, "mid_reset"));
    vecs.push_back(mk(0, 1, 16'h3456, 4'b0000, 4'b0000,  1, 4'b1110, 4'h0, 1, 0, 0, "post_rst_e1"));
    vecs.push_back(mk(0, 1, 16'h3456, 4'b0000, 4'b0000,  3, 4'b1110, 4'h6, 1, 0, 0, "post_rst_d0"));
    vecs.push_back(mk(0, 1, 16'h3456, 4'b0000, 4'b0000,  1, 4'b1101, 4'h5, 1, 1, 0, "post_rst_d1"));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i]);
    end

    // REFRESH_DIV=1: a tick every enabled cycle on a 2-digit display
    repeat (2) @(posedge clk);
    #1;
    check2("r1_reset", 2'b11, 4'h0, 1, 0, 0);
    reset2 = 1'b0; enable2 = 1'b1; digits2 = 8'h7C; dp2 = 2'b10; blank2 = 2'b00;
    @(posedge clk); #1;
    check2("r1_e1", 2'b10, 4'h0, 1, 0, 0);
    @(posedge clk); #1;
    check2("r1_e2", 2'b01, 4'h7, 0, 1, 1);
    @(posedge clk); #1;
    check2("r1_e3", 2'b10, 4'hC, 1, 0, 0);
    @(posedge clk); #1;
    check2("r1_e4", 2'b01, 4'h7, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
